// File: rtl/mdu_pkg.sv
// Shared MDU definitions: op codes also decoded by the control unit, and the
// iteration FSM state encoding.
package mdu_pkg;

    localparam logic [3:0] MDU_default = 4'd0;
    localparam logic [3:0] MDU_mult    = 4'd1;
    localparam logic [3:0] MDU_multu   = 4'd2;
    localparam logic [3:0] MDU_div     = 4'd3;
    localparam logic [3:0] MDU_divu    = 4'd4;
    localparam logic [3:0] MDU_mthi    = 4'd5;
    localparam logic [3:0] MDU_mtlo    = 4'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } mdu_state_e;

    function automatic logic mdu_is_signed(input logic [3:0] op);
        return (op == MDU_mult) || (op == MDU_div);
    endfunction

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration on unsigned magnitudes: shift-add multiply step or
// restoring-divide step. acc is the upper half, wrk the multiplier/quotient.
module mdu_step #(
    parameter int W = 32
) (
    input  logic         is_div_i,
    input  logic [W-1:0] acc_i,
    input  logic [W-1:0] wrk_i,
    input  logic [W-1:0] m_i,
    output logic [W-1:0] acc_o,
    output logic [W-1:0] wrk_o
);

    logic [W:0] sum;
    logic [W:0] shifted;
    logic [W:0] diff;
    logic       fits;

    always_comb begin
        sum     = {1'b0, acc_i} + (wrk_i[0] ? {1'b0, m_i} : '0);
        shifted = {acc_i, wrk_i[W-1]};
        diff    = shifted - {1'b0, m_i};
        // The partial remainder stays below the divisor, so a set top bit
        // of the difference can only mean the trial subtraction borrowed.
        fits    = ~diff[W];
        if (is_div_i) begin
            acc_o = fits ? diff[W-1:0] : shifted[W-1:0];
            wrk_o = {wrk_i[W-2:0], fits};
        end else begin
            acc_o = sum[W:1];
            wrk_o = {sum[0], wrk_i[W-1:1]};
        end
    end

endmodule

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with HI/LO registers, W+2 cycle latency.
// Optional MDU_DIV0_EXC_EN: divide by zero raises div0_exc instead of computing.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [3:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] hi,
`ifdef MDU_DIV0_EXC_EN
    output logic [W-1:0] lo,
    output logic         div0_exc
`else
    output logic [W-1:0] lo
`endif
);

    localparam int CW = $clog2(W);

    mdu_state_e   state_q;
    logic [CW-1:0] cnt_q;
    logic [W-1:0] hi_q, lo_q;
    logic [W-1:0] acc_q, wrk_q, m_q;
    logic         is_div_q, neg_q, neg_rem_q, div0_q;
    logic         busy_q, done_q;

    logic         a_neg, b_neg, is_div_op, is_iter_op, b_zero, launch;
    logic [W-1:0] a_mag, b_mag;
    logic [W-1:0] acc_d, wrk_d;
    logic [2*W-1:0] prod, prod_fix;
    logic [W-1:0] quo_fix, rem_fix, hi_d, lo_d;

    always_comb begin
        a_neg      = mdu_is_signed(op) && a[W-1];
        b_neg      = mdu_is_signed(op) && b[W-1];
        a_mag      = a_neg ? -a : a;
        b_mag      = b_neg ? -b : b;
        is_div_op  = (op == MDU_div) || (op == MDU_divu);
        is_iter_op = is_div_op || (op == MDU_mult) || (op == MDU_multu);
        b_zero     = (b == '0);
`ifdef MDU_DIV0_EXC_EN
        launch     = start && is_iter_op && !(is_div_op && b_zero);
`else
        launch     = start && is_iter_op;
`endif
    end

    mdu_step #(.W(W)) u_step (
        .is_div_i (is_div_q),
        .acc_i    (acc_q),
        .wrk_i    (wrk_q),
        .m_i      (m_q),
        .acc_o    (acc_d),
        .wrk_o    (wrk_d)
    );

    // Sign correction on the finished magnitudes; remainder follows the dividend.
    always_comb begin
        prod     = {acc_q, wrk_q};
        prod_fix = neg_q ? -prod : prod;
        quo_fix  = div0_q ? '1 : (neg_q ? -wrk_q : wrk_q);
        rem_fix  = neg_rem_q ? -acc_q : acc_q;
        hi_d     = is_div_q ? rem_fix : prod_fix[2*W-1:W];
        lo_d     = is_div_q ? quo_fix : prod_fix[W-1:0];
    end

`ifdef MDU_DIV0_EXC_EN
    logic div0_exc_q;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div0_exc_q <= 1'b0;
        end else begin
            div0_exc_q <= (state_q == ST_IDLE) && start && is_div_op && b_zero;
        end
    end
    assign div0_exc = div0_exc_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            acc_q     <= '0;
            wrk_q     <= '0;
            m_q       <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start && op == MDU_mthi) hi_q <= a;
                    if (start && op == MDU_mtlo) lo_q <= a;
                    if (launch) begin
                        acc_q     <= '0;
                        wrk_q     <= is_div_op ? a_mag : b_mag;
                        m_q       <= is_div_op ? b_mag : a_mag;
                        is_div_q  <= is_div_op;
                        neg_q     <= a_neg ^ b_neg;
                        neg_rem_q <= a_neg;
                        div0_q    <= is_div_op && b_zero;
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    acc_q <= acc_d;
                    wrk_q <= wrk_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(W - 1)) state_q <= ST_FIX;
                end
                ST_FIX: begin
                    hi_q    <= hi_d;
                    lo_q    <= lo_d;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed vector bench for mdu_iter at W=32: result table plus hand-written
// multi-cycle sequences (mthi/mtlo, ignored start, reset mid-op, divide by zero).
module tb_mdu_iter;
    import mdu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [3:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done;
    logic [W-1:0] hi, lo;
`ifdef MDU_DIV0_EXC_EN
    logic         div0_exc;
`endif

    int checks = 0;
    int errors = 0;

    mdu_iter #(.W(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
`ifdef MDU_DIV0_EXC_EN
        .lo       (lo),
        .div0_exc (div0_exc)
`else
        .lo       (lo)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the done cycle (or after the bound).
    task automatic run_op(input logic [3:0] o, input logic [31:0] va, input logic [31:0] vb,
                          input int inject, output logic [31:0] r_hi, output logic [31:0] r_lo,
                          output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        r_hi = '0;
        r_lo = '0;
        start = 1'b1; op = o; a = va; b = vb;
        @(negedge clk);
        start = 1'b0; op = MDU_default;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (cyc > 1) @(negedge clk);
            if (inject > 0 && cyc == inject) begin
                start = 1'b1; op = MDU_mult; a = 32'd3; b = 32'd3;
            end else if (inject > 0 && cyc == inject + 1) begin
                start = 1'b0; op = MDU_default;
            end
            if (busy) bcnt++;
            if (done) begin
                lat  = cyc;
                r_hi = hi;
                r_lo = lo;
                break;
            end
        end
        start = 1'b0;
        $display("op=%0d a=%h b=%h -> hi=%h lo=%h latency=%0d busy_cycles=%0d",
                 o, va, vb, r_hi, r_lo, lat, bcnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r_hi, r_lo, old_hi, old_lo;
        int lat, bcnt, ndone;

        vecs[0]  = '{MDU_multu, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1]  = '{MDU_mult,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[2]  = '{MDU_div,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{MDU_divu,  32'd100,      32'd7,        32'd2,        32'd14};
        vecs[4]  = '{MDU_div,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5]  = '{MDU_mult,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[6]  = '{MDU_div,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
        vecs[7]  = '{MDU_multu, 32'h00010000, 32'h00010000, 32'd1,        32'd0};
        vecs[8]  = '{MDU_div,   32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'd2};
        vecs[9]  = '{MDU_mult,  32'd123,      32'd0,        32'd0,        32'd0};
        vecs[10] = '{MDU_mult,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd1};

        rst_n = 1'b0; start = 1'b0; op = MDU_default; a = '0; b = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);

        // mthi then mtlo back to back: visible next cycle, never busy.
        start = 1'b1; op = MDU_mthi; a = 32'h1234;
        @(negedge clk);
        check("mthi_hi", hi, 32'h1234);
        check("mthi_busy", {31'd0, busy}, 32'd0);
        op = MDU_mtlo; a = 32'h5678;
        @(negedge clk);
        check("mtlo_lo", lo, 32'h5678);
        check("mtlo_hi_kept", hi, 32'h1234);
        check("mtlo_busy", {31'd0, busy}, 32'd0);
        start = 1'b0; op = MDU_default;
        @(negedge clk);
        check("mtx_done", {31'd0, done}, 32'd0);
        check("mtx_busy", {31'd0, busy}, 32'd0);

        // Each op starts at the negedge of the previous done cycle.
        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, r_hi, r_lo, lat, bcnt);
            check($sformatf("vec%0d_hi", i), r_hi, vecs[i].exp_hi);
            check($sformatf("vec%0d_lo", i), r_lo, vecs[i].exp_lo);
            check($sformatf("vec%0d_latency", i), lat, W + 2);
            check($sformatf("vec%0d_busy_cycles", i), bcnt, W + 1);
        end

        // A start during CALC must be ignored.
        run_op(MDU_divu, 32'd100, 32'd7, 5, r_hi, r_lo, lat, bcnt);
        check("ignored_start_hi", r_hi, 32'd2);
        check("ignored_start_lo", r_lo, 32'd14);
        check("ignored_start_latency", lat, W + 2);
        @(negedge clk);
        check("ignored_start_idle_after", {31'd0, busy}, 32'd0);

`ifdef MDU_DIV0_EXC_EN
        old_hi = hi; old_lo = lo;
        start = 1'b1; op = MDU_divu; a = 32'd5; b = 32'd0;
        @(negedge clk);
        start = 1'b0; op = MDU_default;
        check("div0_exc_pulse", {31'd0, div0_exc}, 32'd1);
        check("div0_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("div0_exc_clear", {31'd0, div0_exc}, 32'd0);
        check("div0_done", {31'd0, done}, 32'd0);
        check("div0_hi_kept", hi, old_hi);
        check("div0_lo_kept", lo, old_lo);
        $display("divu 5/0 -> div0_exc pulse, hi=%h lo=%h", hi, lo);
`else
        old_hi = '0; old_lo = '0;
        run_op(MDU_divu, 32'h00003039, 32'd0, 0, r_hi, r_lo, lat, bcnt);
        check("div0_hi", r_hi, 32'h00003039);
        check("div0_lo", r_lo, 32'hFFFFFFFF);
        check("div0_latency", lat, W + 2);
        run_op(MDU_div, 32'hFFFFFFF0, 32'd0, 0, r_hi, r_lo, lat, bcnt);
        check("sdiv0_hi", r_hi, 32'hFFFFFFF0);
        check("sdiv0_lo", r_lo, 32'hFFFFFFFF);
`endif

        // Reset asserted in the 10th CALC cycle of a multiply.
        run_op(MDU_multu, 32'd9, 32'd9, 0, r_hi, r_lo, lat, bcnt);
        start = 1'b1; op = MDU_mult; a = 32'd5; b = 32'd6;
        @(negedge clk);
        start = 1'b0; op = MDU_default;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_hi", hi, 32'd0);
        check("midrst_lo", lo, 32'd0);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        check("midrst_no_activity", ndone, 0);
        $display("reset during CALC -> hi=%h lo=%h busy=%0d", hi, lo, busy);
        run_op(MDU_mult, 32'hFFFFFFFB, 32'd6, 0, r_hi, r_lo, lat, bcnt);
        check("postrst_hi", r_hi, 32'hFFFFFFFF);
        check("postrst_lo", r_lo, 32'hFFFFFFE2);
        check("postrst_latency", lat, W + 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
